// File: rtl/nibble_pack_ctrl.sv
// nibble_pack_ctrl: takes a byte stream, picks one or two nibbles from each
// byte according to mode, and packs the picked nibbles two per output byte
// (first nibble in [7:4], second in [3:0]). A partially filled byte can be
// pushed out with flush, padded with PAD. Also taps in_data[3:2] of the
// last accepted byte and counts completed output handshakes.
module nibble_pack_ctrl #(
  parameter logic [3:0] PAD   = 4'h0,
  parameter int         CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [1:0]       field_c,
  output logic [CNT_W-1:0] byte_count
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    HALF     = 2'd1,
    OUT      = 2'd2,
    OUT_HALF = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] hold;
  logic [3:0] n0;
  logic [3:0] n1;
  logic       two_nibbles;
  logic       accept;
  logic       out_fire;

  // Input side is open only when nothing is waiting on the output and a
  // flush is not consuming the held nibble this cycle.
  always_comb begin
    in_ready = (state == EMPTY) || ((state == HALF) && !flush);
  end

  // Decode which nibbles of the offered byte are used and in which order.
  always_comb begin
    two_nibbles = mode[1];
    n0          = in_data[3:0];
    n1          = in_data[7:4];
    case (mode)
      2'd0: begin n0 = in_data[3:0]; n1 = in_data[7:4]; end
      2'd1: begin n0 = in_data[7:4]; n1 = in_data[3:0]; end
      2'd2: begin n0 = in_data[3:0]; n1 = in_data[7:4]; end
      default: begin n0 = in_data[7:4]; n1 = in_data[3:0]; end
    endcase
    accept   = in_valid && in_ready;
    out_fire = out_valid && out_ready;
  end

  // Packing sequencer: state, held nibble, registered output byte, field
  // tap and handshake counter all advance together on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      hold       <= 4'h0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      field_c    <= 2'b00;
      byte_count <= '0;
    end else begin
      if (accept) begin
        field_c <= in_data[3:2];
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            if (two_nibbles) begin
              out_data  <= {n0, n1};
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              hold  <= n0;
              state <= HALF;
            end
          end
        end
        HALF: begin
          if (flush) begin
            out_data  <= {hold, PAD};
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (accept) begin
            out_data  <= {hold, n0};
            out_valid <= 1'b1;
            if (two_nibbles) begin
              hold  <= n1;
              state <= OUT_HALF;
            end else begin
              state <= OUT;
            end
          end
        end
        OUT: begin
          if (out_fire) begin
            out_valid  <= 1'b0;
            byte_count <= byte_count + 1'b1;
            state      <= EMPTY;
          end
        end
        default: begin
          if (out_fire) begin
            out_valid  <= 1'b0;
            byte_count <= byte_count + 1'b1;
            state      <= HALF;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/nibble_pack_ctrl.md
Name: nibble_pack_ctrl

Overview:
Sequencer for the nibble slice/concatenate datapath. It accepts a stream of bytes and, per byte, selects one or two 4-bit fields according to a mode code. The selected nibbles are packed two per output byte: the first collected nibble goes to [7:4] and the second to [3:0]. The block sits between a byte producer and a byte consumer, with valid/ready on both sides, a flush for partial bytes, and a registered 2-bit field tap.

Parameters:
PAD, 4'h0, nibble placed in out_data[3:0] when a half-filled byte is flushed
CNT_W, 8, width of byte_count

Ports:
clk  in  1  single clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
mode  in  2  nibble select for the byte offered on in_data (encoding under Behaviour)
in_valid  in  1  input byte offered
in_ready  out  1  block can take a byte this cycle
in_data  in  8  input byte
flush  in  1  emit the held nibble padded with PAD
out_valid  out  1  out_data holds a packed byte
out_ready  in  1  consumer accepts out_data
out_data  out  8  packed byte
field_c  out  2  in_data[3:2] of the last accepted byte
byte_count  out  CNT_W  number of output handshakes completed, modulo 2^CNT_W

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state goes to EMPTY; hold, out_data, field_c and byte_count go to 0; out_valid goes to 0.
  - Reset mid-operation discards any held nibble and any pending output byte.
- mode encoding, with n0 = first nibble and n1 = second nibble:
  - 0: low nibble only, n0 = in_data[3:0]
  - 1: high nibble only, n0 = in_data[7:4]
  - 2: both nibbles, n0 = [3:0], n1 = [7:4]
  - 3: both nibbles, n0 = [7:4], n1 = [3:0]
- States: EMPTY (no nibble held), HALF (hold valid), OUT (out_valid=1), OUT_HALF (out_valid=1 and hold valid).
- Accept condition: a byte is accepted when in_valid && in_ready at the clk edge.
- in_ready is combinational: 1 when state is EMPTY, or when state is HALF and flush=0. It is 0 in OUT and OUT_HALF, so there is no bypass.
- Transitions on accept:
  - EMPTY, 1-nibble mode: hold=n0, go to HALF.
  - EMPTY, 2-nibble mode: out_data={n0,n1}, go to OUT.
  - HALF, 1-nibble mode: out_data={hold,n0}, go to OUT.
  - HALF, 2-nibble mode: out_data={hold,n0}, hold=n1, go to OUT_HALF.
- Flush: HALF with flush=1 sets out_data={hold,PAD} and goes to OUT. Flush in EMPTY, OUT or OUT_HALF is a no-op and is not remembered.
- Output handshake (out_valid && out_ready):
  - OUT goes to EMPTY; OUT_HALF goes to HALF.
  - byte_count increments by 1 and wraps from 2^CNT_W-1 to 0.
- Output stability: out_data and out_valid are registered. out_data is held stable while out_valid=1 and out_ready=0. out_valid rises the cycle after the completing accept or flush.
- Latency: 1 cycle from the completing accept or flush edge to out_valid=1.
- field_c is updated with in_data[3:2] on every accept, regardless of mode, and is otherwise held.
- hold is only meaningful in HALF and OUT_HALF; its value in other states is don't-care but deterministic (last written value).
- The mode sampled is the value present in the accept cycle.

Test Plan:
1. mode=0; accept 0xF5, then 0x08, out_ready=1 -> out_data=0x58 one cycle after second accept; byte_count=1; field_c=2'b01 after 0xF5, 2'b10 after 0x08.
2. From EMPTY, mode=2 accept 0xA3 -> out_data=0x3A; after reset, mode=3 accept 0xA3 -> out_data=0xA3.
3. mode=1 accept 0xC0 (HALF), then mode=2 accept 0x21 -> out_data=0xC1 and state OUT_HALF with in_ready=0; complete handshake, then mode=0 accept 0x0E -> out_data=0x2E.
4. Flush cases:
   - mode=0 accept 0x07, flush=1 with in_valid=1 -> in_ready=0 that cycle and out_data=0x70 (PAD=0).
   - flush in EMPTY -> no out_valid.
   - PAD=4'hF variant -> 0x7F.
5. Backpressure and reset:
   - Hold out_ready=0 for 5 cycles after out_valid -> out_data constant, in_ready=0, byte_count unchanged.
   - rst=1 while in HALF -> EMPTY, and no stale output after release.
6. Counter wrap: 256 consecutive mode=2 bytes with out_ready=1 -> byte_count returns to 0, with no lost or duplicated bytes (compare against a model).
